// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between pixel-tick source and pixel logic
interface vga_timing_gen_if #(
  parameter int CW = 16
);
  logic          PixEn;
  logic          BorderEn;
  logic [CW-1:0] XAxis;
  logic [CW-1:0] YAxis;
  logic          HS;
  logic          VS;
  logic          ActR;
  logic          border;
  logic          LineStart;
  logic          FrameStart;

  modport master (
    input  PixEn, BorderEn,
    output XAxis, YAxis, HS, VS, ActR, border, LineStart, FrameStart
  );

  modport slave (
    output PixEn, BorderEn,
    input  XAxis, YAxis, HS, VS, ActR, border, LineStart, FrameStart
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster counters with registered sync/active/border/strobes
// Every decoded output is registered from the next counter values, so all outputs align with X/Y.
module vga_timing_gen #(
  parameter int CW       = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BORDER_W = 8,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  vga_timing_gen_if.master  bus
);

  localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam longint CAP     = longint'(1) << CW;

  if (H_TOTAL > CAP || V_TOTAL > CAP) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (2 * BORDER_W > H_ACTIVE || 2 * BORDER_W > V_ACTIVE) begin : g_bad_border
    $fatal(1, "vga_timing_gen: BORDER_W too large for active area");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // One extra bit keeps the region limits exact even when a total reaches 2**CW.
  localparam logic [CW:0] H_ACT   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] BW      = (CW+1)'(BORDER_W);
  localparam logic [CW:0] H_BR    = (CW+1)'(H_ACTIVE - BORDER_W);
  localparam logic [CW:0] V_BR    = (CW+1)'(V_ACTIVE - BORDER_W);
  localparam logic        HS_ON   = (HS_POL != 0);
  localparam logic        VS_ON   = (VS_POL != 0);

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          act_q, act_d, bdr_q, bdr_d;
  logic          ls_q, ls_d, fs_q, fs_d;

  logic [CW-1:0] nx, ny;
  logic [CW:0]   wx, wy;
  logic          nact;

  always_comb begin
    nx   = (x_q == H_LAST) ? '0 : x_q + 1'b1;
    ny   = (x_q != H_LAST) ? y_q : ((y_q == V_LAST) ? '0 : y_q + 1'b1);
    wx   = {1'b0, nx};
    wy   = {1'b0, ny};
    nact = (wx < H_ACT) && (wy < V_ACT);

    x_d   = x_q;
    y_d   = y_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    act_d = act_q;
    bdr_d = bdr_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;

    if (bus.PixEn) begin
      x_d   = nx;
      y_d   = ny;
      hs_d  = ((wx >= HS_BEG) && (wx < HS_END)) ? HS_ON : ~HS_ON;
      vs_d  = ((wy >= VS_BEG) && (wy < VS_END)) ? VS_ON : ~VS_ON;
      act_d = nact;
      bdr_d = bus.BorderEn && nact &&
              ((wx < BW) || (wx >= H_BR) || (wy < BW) || (wy >= V_BR));
      ls_d  = (nx == '0);
      fs_d  = (nx == '0) && (ny == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      x_q   <= H_LAST;
      y_q   <= V_LAST;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      act_q <= 1'b0;
      bdr_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      bdr_q <= bdr_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.XAxis      = x_q;
  assign bus.YAxis      = y_q;
  assign bus.HS         = hs_q;
  assign bus.VS         = vs_q;
  assign bus.ActR       = act_q;
  assign bus.border     = bdr_q;
  assign bus.LineStart  = ls_q;
  assign bus.FrameStart = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen: default and reduced rasters in lockstep
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, bw, hpol, vpol;
  } cfg_t;

  typedef struct {
    int x, y;
    bit hs, vs, act, bdr, ls, fs;
  } st_t;

  // u0: default raster; u1: small raster, positive syncs, 2-pixel border; u2: small, no border.
  cfg_t c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 8, 0, 0};
  cfg_t c1 = '{16, 2, 3, 3, 12, 1, 2, 2, 2, 1, 1};
  cfg_t c2 = '{16, 2, 3, 3, 12, 1, 2, 2, 0, 0, 0};

  logic clk = 1'b0;
  logic rst;
  logic pix;
  logic ben;
  int   checks = 0;
  int   errors = 0;

  st_t m0, m1, m2;
  st_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(16)) if0 ();
  vga_timing_gen_if #(.CW(16)) if1 ();
  vga_timing_gen_if #(.CW(16)) if2 ();

  assign if0.PixEn = pix;
  assign if1.PixEn = pix;
  assign if2.PixEn = pix;
  assign if0.BorderEn = ben;
  assign if1.BorderEn = ben;
  assign if2.BorderEn = ben;

  vga_timing_gen u0 (.Clock(clk), .Reset(rst), .bus(if0));

  vga_timing_gen #(
    .CW(16), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .BORDER_W(2), .HS_POL(1), .VS_POL(1)
  ) u1 (.Clock(clk), .Reset(rst), .bus(if1));

  vga_timing_gen #(
    .CW(16), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .BORDER_W(0), .HS_POL(0), .VS_POL(0)
  ) u2 (.Clock(clk), .Reset(rst), .bus(if2));

  function automatic st_t nxt(st_t s, bit r, bit pe, bit be, cfg_t c);
    st_t n;
    int  ht, vt;
    bit  in_hs, in_vs;
    n  = s;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    if (r) begin
      n.x = ht - 1;  n.y = vt - 1;
      n.hs = (c.hpol == 0);  n.vs = (c.vpol == 0);
      n.act = 0;  n.bdr = 0;  n.ls = 0;  n.fs = 0;
    end else if (!pe) begin
      n.ls = 0;
      n.fs = 0;
    end else begin
      n.x   = (s.x == ht - 1) ? 0 : s.x + 1;
      n.y   = (s.x == ht - 1) ? ((s.y == vt - 1) ? 0 : s.y + 1) : s.y;
      in_hs = (n.x >= c.ha + c.hfp) && (n.x < c.ha + c.hfp + c.hs);
      in_vs = (n.y >= c.va + c.vfp) && (n.y < c.va + c.vfp + c.vs);
      n.hs  = in_hs ? (c.hpol != 0) : (c.hpol == 0);
      n.vs  = in_vs ? (c.vpol != 0) : (c.vpol == 0);
      n.act = (n.x < c.ha) && (n.y < c.va);
      n.bdr = be && n.act && ((n.x < c.bw) || (n.x >= c.ha - c.bw) ||
                              (n.y < c.bw) || (n.y >= c.va - c.bw));
      n.ls  = (n.x == 0);
      n.fs  = (n.x == 0) && (n.y == 0);
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp(string n, st_t e, logic [15:0] x, logic [15:0] y,
                     logic hs, logic vs, logic act, logic bdr, logic ls, logic fs);
    chk({n, ".X"}, 32'(x), e.x);
    chk({n, ".Y"}, 32'(y), e.y);
    chk({n, ".HS"}, 32'(hs), 32'(e.hs));
    chk({n, ".VS"}, 32'(vs), 32'(e.vs));
    chk({n, ".ActR"}, 32'(act), 32'(e.act));
    chk({n, ".border"}, 32'(bdr), 32'(e.bdr));
    chk({n, ".LineStart"}, 32'(ls), 32'(e.ls));
    chk({n, ".FrameStart"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic step(bit r, bit pe, bit be);
    st_t e;
    int  px, py;
    rst = r;  pix = pe;  ben = be;
    m0 = nxt(m0, r, pe, be, c0);  q0.push_back(m0);
    m1 = nxt(m1, r, pe, be, c1);  q1.push_back(m1);
    m2 = nxt(m2, r, pe, be, c2);  q2.push_back(m2);
    @(posedge clk);
    #1;
    e = q0.pop_front();
    cmp("u0", e, if0.XAxis, if0.YAxis, if0.HS, if0.VS, if0.ActR, if0.border, if0.LineStart, if0.FrameStart);
    e = q1.pop_front();
    cmp("u1", e, if1.XAxis, if1.YAxis, if1.HS, if1.VS, if1.ActR, if1.border, if1.LineStart, if1.FrameStart);
    e = q2.pop_front();
    cmp("u2", e, if2.XAxis, if2.YAxis, if2.HS, if2.VS, if2.ActR, if2.border, if2.LineStart, if2.FrameStart);
    chk("u2_border_zero", 32'(if2.border), 0);
    if (!r && pe && be) begin
      px = int'(if1.XAxis);
      py = int'(if1.YAxis);
      if (px == 1  && py == 5)  chk("probe_1_5",   32'(if1.border), 1);
      if (px == 2  && py == 5)  chk("probe_2_5",   32'(if1.border), 0);
      if (px == 14 && py == 2)  chk("probe_14_2",  32'(if1.border), 1);
      if (px == 13 && py == 9)  chk("probe_13_9",  32'(if1.border), 0);
      if (px == 6  && py == 10) chk("probe_6_10",  32'(if1.border), 1);
      if (px == 16 && py == 0)  chk("probe_16_0",  32'(if1.border), 0);
    end
  endtask

  initial begin
    int hs0_lo, hs1_on, ls_cnt, ls_first, ls_second;
    int fs_a, fs_b, vs_lo, bdr_hi, px, py, found;
    bit prev_ls, pe;

    // Reset held three cycles with PixEn high; reset must win.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1);
      chk("rst_X", 32'(if0.XAxis), 799);
      chk("rst_Y", 32'(if0.YAxis), 524);
      chk("rst_HS", 32'(if0.HS), 1);
      chk("rst_VS", 32'(if0.VS), 1);
      chk("rst_ActR", 32'(if0.ActR), 0);
    end
    step(0, 1, 1);
    chk("first_X", 32'(if0.XAxis), 0);
    chk("first_Y", 32'(if0.YAxis), 0);
    chk("first_ActR", 32'(if0.ActR), 1);
    chk("first_border", 32'(if0.border), 1);
    chk("first_LineStart", 32'(if0.LineStart), 1);
    chk("first_FrameStart", 32'(if0.FrameStart), 1);

    // Two full default lines: HS window, ActR edge, LineStart spacing.
    hs0_lo = 0;  hs1_on = 0;  ls_cnt = 0;  ls_first = -1;  ls_second = -1;
    for (int i = 0; i < 1600; i++) begin
      step(0, 1, 1);
      if (if0.HS === 1'b0) hs0_lo++;
      if (if1.HS === 1'b1) hs1_on++;
      if (if0.XAxis == 16'd640) chk("act_fall_640", 32'(if0.ActR), 0);
      if (if0.XAxis == 16'd639) chk("act_at_639", 32'(if0.ActR), 1);
      if (if0.LineStart === 1'b1) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
    end
    chk("hs_low_ticks", hs0_lo, 192);
    chk("hs_pol1_ticks", hs1_on, 198);
    chk("ls_count", ls_cnt, 2);
    chk("ls_period", ls_second - ls_first, 800);

    // Full small frames at full rate: FrameStart period and VS width.
    fs_a = -1;  fs_b = -1;  vs_lo = 0;
    for (int i = 0; i < 1000; i++) begin
      px = int'(if2.XAxis);
      py = int'(if2.YAxis);
      step(0, 1, 1);
      if (px == 23 && py == 16) begin
        chk("wrap_X", 32'(if2.XAxis), 0);
        chk("wrap_Y", 32'(if2.YAxis), 0);
      end
      if (if2.FrameStart === 1'b1) begin
        if (fs_a < 0) fs_a = i;
        else begin
          fs_b = i;
          break;
        end
      end
      if (fs_a >= 0 && if2.VS === 1'b0) vs_lo++;
    end
    chk("fs_period_full", fs_b - fs_a, 408);
    chk("vs_low_ticks", vs_lo, 48);

    // Half-rate ticks: period doubles, strobes stay one cycle wide.
    fs_a = -1;  fs_b = -1;  prev_ls = 0;  pe = 1;
    for (int i = 0; i < 2000; i++) begin
      step(0, pe, 1);
      pe = ~pe;
      if (prev_ls) chk("ls_width", 32'(if2.LineStart), 0);
      prev_ls = if2.LineStart;
      if (if2.FrameStart === 1'b1) begin
        if (fs_a < 0) fs_a = i;
        else begin
          fs_b = i;
          break;
        end
      end
    end
    chk("fs_period_half", fs_b - fs_a, 816);

    // BorderEn low for a whole small frame.
    bdr_hi = 0;
    for (int i = 0; i < 408; i++) begin
      step(0, 1, 0);
      if (if1.border !== 1'b0) bdr_hi++;
    end
    chk("borderen_off", bdr_hi, 0);

    // Reset in mid-frame, then restart.
    found = 0;
    for (int i = 0; i < 500; i++) begin
      step(0, 1, 1);
      if (if1.XAxis == 16'd6 && if1.YAxis == 16'd10) begin
        found = 1;
        break;
      end
    end
    chk("midframe_reached", found, 1);
    step(1, 1, 1);
    chk("mid_rst_X0", 32'(if0.XAxis), 799);
    chk("mid_rst_Y0", 32'(if0.YAxis), 524);
    chk("mid_rst_X1", 32'(if1.XAxis), 23);
    chk("mid_rst_Y1", 32'(if1.YAxis), 16);
    chk("mid_rst_HS1", 32'(if1.HS), 0);
    chk("mid_rst_ActR", 32'(if0.ActR), 0);
    chk("mid_rst_FS", 32'(if0.FrameStart), 0);
    step(0, 1, 1);
    chk("restart_FS0", 32'(if0.FrameStart), 1);
    chk("restart_FS1", 32'(if1.FrameStart), 1);
    chk("restart_X1", 32'(if1.XAxis), 0);
    step(0, 0, 1);
    chk("hold_FS_clear", 32'(if0.FrameStart), 0);
    chk("hold_X", 32'(if0.XAxis), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
